// File: rtl/tl_master_arbiter.sv
// tl_master_arbiter
//   Shares one downstream TileLink-UL A/D port among NUM_MASTERS upstream
//   masters. A-channel requests are granted round-robin, and a grant is held
//   until its handshake completes. The grant index is prepended to a_source,
//   and D responses are routed back by that index. A per-master count of
//   outstanding requests stops a master from issuing once it reaches
//   MAX_OUTSTANDING.
// Ports
//   clk, reset        : clock, asynchronous active-high reset
//   m_a_*             : packed per-master A channels (master i in slice i)
//   m_d_*             : per-master D valid/ready plus shared D payload
//   a_*               : downstream A channel, a_source = {grant_idx, source}
//   d_*               : downstream D channel
//   err_unmapped      : one-cycle pulse when a D beat was dropped
module tl_master_arbiter #(
  parameter int NUM_MASTERS     = 2,
  parameter int XLEN            = 32,
  parameter int SID_WIDTH       = 2,
  parameter int MAX_OUTSTANDING = 4,
  localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1,
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_MASTERS-1:0]          m_a_valid,
  output logic [NUM_MASTERS-1:0]          m_a_ready,
  input  logic [NUM_MASTERS*3-1:0]        m_a_opcode,
  input  logic [NUM_MASTERS*3-1:0]        m_a_param,
  input  logic [NUM_MASTERS*3-1:0]        m_a_size,
  input  logic [NUM_MASTERS*SID_WIDTH-1:0] m_a_source,
  input  logic [NUM_MASTERS*XLEN-1:0]     m_a_address,
  input  logic [NUM_MASTERS*XLEN/8-1:0]   m_a_mask,
  input  logic [NUM_MASTERS*XLEN-1:0]     m_a_data,
  output logic [NUM_MASTERS-1:0]          m_d_valid,
  input  logic [NUM_MASTERS-1:0]          m_d_ready,
  output logic [2:0]                      m_d_opcode,
  output logic [1:0]                      m_d_param,
  output logic [2:0]                      m_d_size,
  output logic [SID_WIDTH-1:0]            m_d_source,
  output logic [XLEN-1:0]                 m_d_data,
  output logic                            m_d_corrupt,
  output logic                            m_d_denied,
  output logic                            a_valid,
  input  logic                            a_ready,
  output logic [2:0]                      a_opcode,
  output logic [2:0]                      a_param,
  output logic [2:0]                      a_size,
  output logic [SID_WIDTH+IDX_W-1:0]      a_source,
  output logic [XLEN-1:0]                 a_address,
  output logic [XLEN/8-1:0]               a_mask,
  output logic [XLEN-1:0]                 a_data,
  input  logic                            d_valid,
  output logic                            d_ready,
  input  logic [2:0]                      d_opcode,
  input  logic [1:0]                      d_param,
  input  logic [2:0]                      d_size,
  input  logic [SID_WIDTH+IDX_W-1:0]      d_source,
  input  logic [XLEN-1:0]                 d_data,
  input  logic                            d_corrupt,
  input  logic                            d_denied,
  output logic                            err_unmapped
);

  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_OUTSTANDING);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MASTERS - 1);

  typedef enum logic [0:0] {ARB = 1'b0, LOCKED = 1'b1} state_t;

  state_t               state_r;
  logic [IDX_W-1:0]     lock_idx_r;
  logic [IDX_W-1:0]     rr_ptr_r;
  logic [CNT_W-1:0]     cnt_r [NUM_MASTERS];
  logic                 err_unmapped_r;

  logic [NUM_MASTERS-1:0] eligible_s;
  logic                 arb_found_s;
  logic [IDX_W-1:0]     arb_idx_s;
  logic [IDX_W-1:0]     grant_s;
  logic                 lock_valid_s;
  logic                 a_valid_s;
  logic                 a_fire_s;
  logic [IDX_W-1:0]     d_idx_s;
  logic                 d_mapped_s;

  // Index k places after base, wrapping at NUM_MASTERS.
  function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base, input int k);
    wrap_idx = IDX_W'((int'(base) + k) % NUM_MASTERS);
  endfunction

  // Round-robin successor of a master index.
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
    next_idx = (idx == LAST_IDX) ? IDX_W'(0) : idx + IDX_W'(1);
  endfunction

  // Eligibility and round-robin search starting at rr_ptr.
  always_comb begin
    eligible_s  = '0;
    arb_found_s = 1'b0;
    arb_idx_s   = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      eligible_s[i] = m_a_valid[i] && (cnt_r[i] < MAX_CNT);
    end
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (!arb_found_s && eligible_s[wrap_idx(rr_ptr_r, k)]) begin
        arb_found_s = 1'b1;
        arb_idx_s   = wrap_idx(rr_ptr_r, k);
      end else begin
        arb_found_s = arb_found_s;
      end
    end
  end

  // Grant selection, A-channel mux and per-master ready.
  // While locked the held master keeps the grant whatever its count is.
  always_comb begin
    lock_valid_s = 1'b0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (lock_idx_r == IDX_W'(i)) begin
        lock_valid_s = m_a_valid[i];
      end else begin
        lock_valid_s = lock_valid_s;
      end
    end
    if (state_r == LOCKED) begin
      grant_s   = lock_idx_r;
      a_valid_s = lock_valid_s;
    end else begin
      grant_s   = arb_idx_s;
      a_valid_s = arb_found_s;
    end
    a_fire_s  = a_valid_s && a_ready;
    a_opcode  = 3'b000;
    a_param   = 3'b000;
    a_size    = 3'b000;
    a_source  = '0;
    a_address = '0;
    a_mask    = '0;
    a_data    = '0;
    m_a_ready = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (grant_s == IDX_W'(i)) begin
        a_opcode     = m_a_opcode[i*3 +: 3];
        a_param      = m_a_param[i*3 +: 3];
        a_size       = m_a_size[i*3 +: 3];
        a_source     = {grant_s, m_a_source[i*SID_WIDTH +: SID_WIDTH]};
        a_address    = m_a_address[i*XLEN +: XLEN];
        a_mask       = m_a_mask[i*(XLEN/8) +: (XLEN/8)];
        a_data       = m_a_data[i*XLEN +: XLEN];
        m_a_ready[i] = a_valid_s && a_ready;
      end else begin
        m_a_ready[i] = 1'b0;
      end
    end
  end

  assign a_valid = a_valid_s;

  // D routing by the index bits of d_source. A beat for an unknown index or
  // for a master with nothing outstanding is accepted and discarded.
  always_comb begin
    d_idx_s    = d_source[SID_WIDTH +: IDX_W];
    d_mapped_s = 1'b0;
    m_d_valid  = '0;
    d_ready    = 1'b1;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (d_idx_s == IDX_W'(i)) begin
        d_mapped_s = (cnt_r[i] != '0);
      end else begin
        d_mapped_s = d_mapped_s;
      end
    end
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (d_mapped_s && (d_idx_s == IDX_W'(i))) begin
        m_d_valid[i] = d_valid;
        d_ready      = m_d_ready[i];
      end else begin
        m_d_valid[i] = 1'b0;
      end
    end
  end

  assign m_d_opcode   = d_opcode;
  assign m_d_param    = d_param;
  assign m_d_size     = d_size;
  assign m_d_source   = d_source[SID_WIDTH-1:0];
  assign m_d_data     = d_data;
  assign m_d_corrupt  = d_corrupt;
  assign m_d_denied   = d_denied;
  assign err_unmapped = err_unmapped_r;

  // Arbitration FSM: lock the grant when the downstream stalls it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= ARB;
      lock_idx_r <= '0;
      rr_ptr_r   <= '0;
    end else begin
      case (state_r)
        ARB: begin
          if (arb_found_s && !a_ready) begin
            state_r    <= LOCKED;
            lock_idx_r <= arb_idx_s;
          end else if (arb_found_s) begin
            rr_ptr_r <= next_idx(arb_idx_s);
          end else begin
            rr_ptr_r <= rr_ptr_r;
          end
        end
        LOCKED: begin
          if (a_fire_s) begin
            state_r  <= ARB;
            rr_ptr_r <= next_idx(lock_idx_r);
          end else begin
            state_r <= LOCKED;
          end
        end
        default: begin
          state_r <= ARB;
        end
      endcase
    end
  end

  // Outstanding counters; an A fire and a D fire on the same master cancel.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_MASTERS; i++) begin
        cnt_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_MASTERS; i++) begin
        if (a_fire_s && (grant_s == IDX_W'(i)) && !(m_d_valid[i] && d_ready) && (cnt_r[i] != MAX_CNT)) begin
          cnt_r[i] <= cnt_r[i] + CNT_W'(1);
        end else if (m_d_valid[i] && d_ready && !(a_fire_s && (grant_s == IDX_W'(i))) && (cnt_r[i] != '0)) begin
          cnt_r[i] <= cnt_r[i] - CNT_W'(1);
        end else begin
          cnt_r[i] <= cnt_r[i];
        end
      end
    end
  end

  // Dropped-beat flag, one cycle after the beat.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_unmapped_r <= 1'b0;
    end else begin
      err_unmapped_r <= d_valid && !d_mapped_s;
    end
  end

endmodule

// File: tb/tb_tl_master_arbiter.sv
// Bench for tl_master_arbiter (2 masters, 32-bit, 2-bit source, max 4 in flight).
// Directed scenarios with literal expectations, then randomized traffic checked
// every cycle against a behavioural model.
module tb_tl_master_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  m_a_valid = '0;
  logic [1:0]  m_a_ready;
  logic [5:0]  m_a_opcode = '0, m_a_param = '0, m_a_size = '0;
  logic [3:0]  m_a_source = '0;
  logic [63:0] m_a_address = '0;
  logic [7:0]  m_a_mask = '0;
  logic [63:0] m_a_data = '0;
  logic [1:0]  m_d_valid;
  logic [1:0]  m_d_ready = '0;
  logic [2:0]  m_d_opcode, m_d_size;
  logic [1:0]  m_d_param;
  logic [1:0]  m_d_source;
  logic [31:0] m_d_data;
  logic        m_d_corrupt, m_d_denied;
  logic        a_valid;
  logic        a_ready = 1'b0;
  logic [2:0]  a_opcode, a_param, a_size;
  logic [2:0]  a_source;
  logic [31:0] a_address, a_data;
  logic [3:0]  a_mask;
  logic        d_valid = 1'b0;
  logic        d_ready;
  logic [2:0]  d_opcode = '0, d_size = '0;
  logic [1:0]  d_param = '0;
  logic [2:0]  d_source = '0;
  logic [31:0] d_data = '0;
  logic        d_corrupt = 1'b0, d_denied = 1'b0;
  logic        err_unmapped;

  int errors = 0;
  int checks = 0;

  // Behavioural model state
  int mcnt [2];
  int mrr;
  bit mlocked;
  int mlock_idx;
  bit merr_exp;

  tl_master_arbiter dut (
    .clk(clk), .reset(reset),
    .m_a_valid(m_a_valid), .m_a_ready(m_a_ready),
    .m_a_opcode(m_a_opcode), .m_a_param(m_a_param), .m_a_size(m_a_size),
    .m_a_source(m_a_source), .m_a_address(m_a_address), .m_a_mask(m_a_mask),
    .m_a_data(m_a_data),
    .m_d_valid(m_d_valid), .m_d_ready(m_d_ready),
    .m_d_opcode(m_d_opcode), .m_d_param(m_d_param), .m_d_size(m_d_size),
    .m_d_source(m_d_source), .m_d_data(m_d_data),
    .m_d_corrupt(m_d_corrupt), .m_d_denied(m_d_denied),
    .a_valid(a_valid), .a_ready(a_ready),
    .a_opcode(a_opcode), .a_param(a_param), .a_size(a_size),
    .a_source(a_source), .a_address(a_address), .a_mask(a_mask), .a_data(a_data),
    .d_valid(d_valid), .d_ready(d_ready),
    .d_opcode(d_opcode), .d_param(d_param), .d_size(d_size),
    .d_source(d_source), .d_data(d_data),
    .d_corrupt(d_corrupt), .d_denied(d_denied),
    .err_unmapped(err_unmapped)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Advance one clock; return just after the edge so inputs can be driven.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    m_a_valid = '0;
    a_ready   = 1'b0;
    d_valid   = 1'b0;
    m_d_ready = '0;
    d_source  = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    mcnt[0] = 0; mcnt[1] = 0;
    mrr = 0; mlocked = 1'b0; mlock_idx = 0; merr_exp = 1'b0;
  endtask

  // One randomized cycle: drive, compare against the model, advance the model.
  task automatic rand_cycle();
    bit       exp_av, exp_dr, mapped, afire, dfire;
    int       g, didx, j;
    logic [1:0] exp_mar, exp_mdv;
    logic [2:0] exp_src;
    tick();
    if ($urandom_range(299) == 0) begin
      reset = 1'b1;
      #1;
      reset = 1'b0;
      mcnt[0] = 0; mcnt[1] = 0;
      mrr = 0; mlocked = 1'b0; mlock_idx = 0; merr_exp = 1'b0;
    end
    for (int i = 0; i < 2; i++) begin
      if (!(mlocked && i == mlock_idx)) begin
        m_a_valid[i]          = ($urandom_range(2) != 0);
        m_a_opcode[i*3 +: 3]  = 3'($urandom);
        m_a_param[i*3 +: 3]   = 3'($urandom);
        m_a_size[i*3 +: 3]    = 3'($urandom);
        m_a_source[i*2 +: 2]  = 2'($urandom);
        m_a_address[i*32 +: 32] = $urandom;
        m_a_mask[i*4 +: 4]    = 4'($urandom);
        m_a_data[i*32 +: 32]  = $urandom;
      end
    end
    a_ready   = ($urandom_range(9) < 7);
    d_valid   = ($urandom_range(1) == 1);
    d_source  = 3'($urandom);
    d_data    = $urandom;
    d_opcode  = 3'($urandom);
    m_d_ready = 2'($urandom);
    #2;
    // expected A side
    exp_av = 1'b0;
    g = 0;
    if (mlocked) begin
      g = mlock_idx;
      exp_av = m_a_valid[g];
    end else begin
      for (int k = 0; k < 2; k++) begin
        j = (mrr + k) % 2;
        if (!exp_av && m_a_valid[j] && mcnt[j] < 4) begin
          exp_av = 1'b1;
          g = j;
        end
      end
    end
    exp_mar = (exp_av && a_ready) ? (2'b01 << g) : 2'b00;
    // expected D side
    didx   = int'(d_source[2]);
    mapped = (didx < 2) && (mcnt[didx] > 0);
    exp_mdv = (d_valid && mapped) ? (2'b01 << didx) : 2'b00;
    exp_dr  = mapped ? m_d_ready[didx] : 1'b1;
    chk("a_valid", 64'(a_valid), 64'(exp_av));
    chk("m_a_ready", 64'(m_a_ready), 64'(exp_mar));
    if (exp_av) begin
      exp_src = {g[0], m_a_source[g*2 +: 2]};
      chk("a_source", 64'(a_source), 64'(exp_src));
      chk("a_address", 64'(a_address), 64'(m_a_address[g*32 +: 32]));
      chk("a_data", 64'(a_data), 64'(m_a_data[g*32 +: 32]));
      chk("a_opcode", 64'(a_opcode), 64'(m_a_opcode[g*3 +: 3]));
      chk("a_mask", 64'(a_mask), 64'(m_a_mask[g*4 +: 4]));
    end
    chk("m_d_valid", 64'(m_d_valid), 64'(exp_mdv));
    chk("d_ready", 64'(d_ready), 64'(exp_dr));
    if (d_valid && mapped) begin
      chk("m_d_source", 64'(m_d_source), 64'(d_source[1:0]));
      chk("m_d_data", 64'(m_d_data), 64'(d_data));
    end
    chk("err_unmapped", 64'(err_unmapped), 64'(merr_exp));
    // model advance for the coming edge
    afire = exp_av && a_ready;
    dfire = d_valid && mapped && exp_dr;
    if (afire && mcnt[g] < 4) mcnt[g] = mcnt[g] + 1;
    if (dfire && mcnt[didx] > 0) mcnt[didx] = mcnt[didx] - 1;
    if (!mlocked && exp_av && !a_ready) begin
      mlocked = 1'b1;
      mlock_idx = g;
    end else if (afire) begin
      mlocked = 1'b0;
      mrr = (g + 1) % 2;
    end
    merr_exp = d_valid && !mapped;
  endtask

  initial begin
    do_reset();
    // reset state
    #2;
    chk("rst_a_valid", 64'(a_valid), 64'd0);
    chk("rst_m_a_ready", 64'(m_a_ready), 64'd0);
    chk("rst_m_d_valid", 64'(m_d_valid), 64'd0);
    chk("rst_err", 64'(err_unmapped), 64'd0);

    // 1: alternating grants with both masters requesting
    m_a_source = 4'b0110;  // m0 src=2'b10, m1 src=2'b01
    m_a_valid = 2'b11;
    a_ready = 1'b1;
    #2; chk("t1_src0", 64'(a_source), 64'h2);
    chk("t1_rdy0", 64'(m_a_ready), 64'h1);
    tick(); #2; chk("t1_src1", 64'(a_source), 64'h5);
    tick(); #2; chk("t1_src2", 64'(a_source), 64'h2);
    tick(); #2; chk("t1_src3", 64'(a_source), 64'h5);

    // 2: grant held through a stall, then rotates
    do_reset();
    m_a_valid = 2'b01;
    a_ready = 1'b0;
    #2; chk("t2_c0", 64'(a_source[2]), 64'd0);
    tick(); m_a_valid = 2'b11;
    #2; chk("t2_c1", 64'(a_source[2]), 64'd0);
    chk("t2_c1_rdy", 64'(m_a_ready), 64'd0);
    tick(); #2; chk("t2_c2", 64'(a_source[2]), 64'd0);
    tick(); a_ready = 1'b1;
    #2; chk("t2_c3", 64'(a_source[2]), 64'd0);
    chk("t2_c3_rdy", 64'(m_a_ready), 64'h1);
    tick(); #2; chk("t2_c4", 64'(a_source[2]), 64'd1);
    chk("t2_c4_rdy", 64'(m_a_ready), 64'h2);

    // 3: throttling at four outstanding, released by one response
    do_reset();
    m_a_valid = 2'b10;
    a_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #2; chk("t3_issue", 64'(m_a_ready), 64'h2);
      tick();
    end
    #2; chk("t3_block_av", 64'(a_valid), 64'd0);
    chk("t3_block_rdy", 64'(m_a_ready), 64'd0);
    tick();
    d_valid = 1'b1; d_source = 3'b101; m_d_ready = 2'b10;
    #2; chk("t3_mdv", 64'(m_d_valid), 64'h2);
    chk("t3_mdsrc", 64'(m_d_source), 64'h1);
    chk("t3_dready", 64'(d_ready), 64'd1);
    tick(); d_valid = 1'b0;
    #2; chk("t3_resume", 64'(a_valid), 64'd1);
    chk("t3_resume_rdy", 64'(m_a_ready), 64'h2);

    // 4: response for a master with nothing outstanding is dropped
    do_reset();
    d_valid = 1'b1; d_source = 3'b100; m_d_ready = 2'b00;
    #2; chk("t4_dready", 64'(d_ready), 64'd1);
    chk("t4_mdv", 64'(m_d_valid), 64'd0);
    chk("t4_err_pre", 64'(err_unmapped), 64'd0);
    tick(); d_valid = 1'b0;
    #2; chk("t4_err", 64'(err_unmapped), 64'd1);
    tick(); #2; chk("t4_err_post", 64'(err_unmapped), 64'd0);

    // 5: simultaneous A and D fire on m0 with two outstanding
    do_reset();
    m_a_valid = 2'b01; a_ready = 1'b1;
    tick(); tick();
    d_valid = 1'b1; d_source = 3'b000; m_d_ready = 2'b01;
    #2; chk("t5_both_a", 64'(m_a_ready), 64'h1);
    chk("t5_both_d", 64'(m_d_valid), 64'h1);
    tick(); d_valid = 1'b0;
    #2; chk("t5_third", 64'(a_valid), 64'd1);
    tick(); #2; chk("t5_fourth", 64'(a_valid), 64'd1);
    tick(); #2; chk("t5_full", 64'(a_valid), 64'd0);

    // 6: reset while locked
    do_reset();
    m_a_valid = 2'b11; a_ready = 1'b1;
    tick(); tick(); tick();      // grants 0,1,0
    m_a_valid = 2'b01;
    tick();                      // grant 0 again
    m_a_valid = 2'b11; a_ready = 1'b0;
    #2; chk("t6_pre", 64'(a_source[2]), 64'd1);
    tick(); #2; chk("t6_locked", 64'(a_source[2]), 64'd1);
    reset = 1'b1; #1; reset = 1'b0;
    #1; chk("t6_after_av", 64'(a_valid), 64'd1);
    chk("t6_after_idx", 64'(a_source[2]), 64'd0);
    m_a_valid = 2'b00;
    d_valid = 1'b1; d_source = 3'b000; m_d_ready = 2'b11;
    #1; chk("t6_drop_mdv", 64'(m_d_valid), 64'd0);
    chk("t6_drop_rdy", 64'(d_ready), 64'd1);

    // randomized traffic against the model
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      rand_cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
